mem_stage: RTL
==============

Name: mem_stage

Overview:
Memory-access stage of the 5-stage MIPS pipeline. It sits directly downstream of the EX/MEM pipeline register and consumes its MEM-side outputs.
- Resolves the branch decision.
- Performs data-memory loads and stores.
- Hosts the memory-mapped timer, LED and systick peripherals, and raises the interrupt request.
- Produces the write-back data and control that the MEM/WB register latches.

Parameters:
DMEM_WORDS, 256, number of 32-bit words in data memory (power of two)
TIMER_BASE, 32'h4000_0000, base byte address of the peripheral window

Ports:
clk  input  1  pipeline clock
reset  input  1  synchronous, active-high reset
MemWriteMEM  input  1  store enable
MemReadMEM  input  1  load enable
BranchMEM  input  1  instruction is a conditional branch
ALUequalMEM  input  1  ALU zero/equal flag
MemtoRegMEM  input  1  select load data for write-back
RegWriteMEM  input  1  register write enable (passed through)
branchaddrMEM  input  32  branch target
ALUoutMEM  input  32  effective byte address / ALU result
memwritedataMEM  input  32  store data
regwriteaddrMEM  input  5  destination register (passed through)
PCSrc  output  1  take branch; also flushes IF/ID, ID/EX, EX/MEM
branchtarget  output  32  next PC when PCSrc=1
wbdataMEM  output  32  write-back data
RegWriteWB_in  output  1  = RegWriteMEM
regwriteaddrWB_in  output  5  = regwriteaddrMEM
leds  output  8  LED register
intterupt  output  1  timer interrupt request to the CPU core

Behaviour:
Clock and reset:
- One clock domain, clk.
- reset is synchronous and active-high.
- All state changes happen on posedge clk.

Branch resolution:
- PCSrc = BranchMEM & ALUequalMEM, combinational.
- branchtarget = branchaddrMEM.

Address decode (on ALUoutMEM):
- Byte addresses 0 .. DMEM_WORDS*4-1 map to DMEM. Word index = ALUoutMEM[log2(DMEM_WORDS)+1:2]; address bits [1:0] are ignored (word access only).
- TIMER_BASE+0x00: TH, read/write.
- TIMER_BASE+0x04: TL, read/write.
- TIMER_BASE+0x08: TCON, read/write, bits [2:0]. Bit 0 = enable, bit 1 = irq enable, bit 2 = irq status.
- TIMER_BASE+0x0C: LED, read/write, bits [7:0].
- TIMER_BASE+0x14: SYSTICK, read-only.
- Any other address is unmapped: writes are ignored, reads return 0.

Stores:
- When MemWriteMEM=1, the addressed location is written at posedge clk.
- Stores to SYSTICK are ignored.

Loads:
- Combinational, zero added latency.
- memread = mapped value when MemReadMEM=1; otherwise memread = 0.
- wbdataMEM = MemtoRegMEM ? memread : ALUoutMEM.

DMEM:
- Contents are not cleared by reset.
- A load and a store to the same word in the same cycle: the load returns the old value.

Timer, per cycle:
- SYSTICK increments by 1 every cycle, wrapping from 0xFFFFFFFF to 0.
- If TCON[0]=1:
  - TL == 0xFFFFFFFF: TL <= TH, and overflow = 1.
  - Otherwise: TL <= TL + 1.
- If TCON[0]=0, TL holds.

Simultaneous events:
- A store to TL or TH in the same cycle overrides the counter update for that register.
- TCON[1:0] next value = store data when TCON is written; otherwise it holds.
- TCON[2] next value = (TCON store ? wdata[2] : TCON[2]) | (overflow & TCON[1]). An overflow is never lost to a simultaneous clear.

Interrupt:
- intterupt = TCON[2], registered, asserted the cycle after the overflow edge.
- It stays high until software writes TCON[2]=0.

Reset values:
- TH=0, TL=0, TCON=0, LED=0, SYSTICK=0, so leds=0 and intterupt=0.
- Combinational outputs follow the inputs, which are 0 because EX/MEM is in reset.
- Reset asserted mid-count: all registers return to 0 on the next edge and the counter stops.
- Reset takes priority over a same-cycle store.

Test Plan:
- Store 0xDEADBEEF to address 0x10, then load 0x10 with MemtoRegMEM=1 -> wbdataMEM=0xDEADBEEF. Load 0x10 with MemReadMEM=0 and ALUoutMEM=0x10 -> wbdataMEM=0x10.
- BranchMEM=1, ALUequalMEM=1, branchaddrMEM=0x40 -> PCSrc=1, branchtarget=0x40. With ALUequalMEM=0 -> PCSrc=0.
- Store TH=0xFFFFFFFD, TL=0xFFFFFFFD, TCON=3 -> TL steps FFFFFFFE, FFFFFFFF, then reloads FFFFFFFD. intterupt rises the cycle after the reload edge and stays high. Store TCON=3 -> intterupt falls next cycle.
- Store TCON=3 in the exact cycle TL wraps -> TCON[2] stays 1 and intterupt remains asserted.
- Store LED=0x1A5 -> leds=0xA5. Load SYSTICK on two loads 5 cycles apart -> values differ by 5. Store to SYSTICK -> no effect. Load 0x40000020 -> 0.
- Run the timer, then assert reset for 1 cycle -> TL=0, TCON=0, leds=0, intterupt=0 on the next edge. DMEM word 0x10 still reads 0xDEADBEEF.

Source files
------------

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline: branch resolve, data memory, and the
// memory-mapped timer / LED / systick peripherals that drive the interrupt line.
`timescale 1ns/1ps

module mem_stage #(
    parameter int unsigned DMEM_WORDS = 256,
    parameter logic [31:0] TIMER_BASE = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteMEM,
    input  logic        MemReadMEM,
    input  logic        BranchMEM,
    input  logic        ALUequalMEM,
    input  logic        MemtoRegMEM,
    input  logic        RegWriteMEM,
    input  logic [31:0] branchaddrMEM,
    input  logic [31:0] ALUoutMEM,
    input  logic [31:0] memwritedataMEM,
    input  logic [4:0]  regwriteaddrMEM,
    output logic        PCSrc,
    output logic [31:0] branchtarget,
    output logic [31:0] wbdataMEM,
    output logic        RegWriteWB_in,
    output logic [4:0]  regwriteaddrWB_in,
    output logic [7:0]  leds,
    output logic        intterupt
);

    localparam int unsigned DmemAw = $clog2(DMEM_WORDS);

    localparam logic [31:0] AddrTh      = TIMER_BASE + 32'h00;
    localparam logic [31:0] AddrTl      = TIMER_BASE + 32'h04;
    localparam logic [31:0] AddrTcon    = TIMER_BASE + 32'h08;
    localparam logic [31:0] AddrLed     = TIMER_BASE + 32'h0C;
    localparam logic [31:0] AddrSysTick = TIMER_BASE + 32'h14;

    // Branch resolution
    assign PCSrc        = BranchMEM & ALUequalMEM;
    assign branchtarget = branchaddrMEM;

    // Write-back control pass-through
    assign RegWriteWB_in     = RegWriteMEM;
    assign regwriteaddrWB_in = regwriteaddrMEM;

    // Address decode
    logic              isDmem;
    logic              hitTh;
    logic              hitTl;
    logic              hitTcon;
    logic              hitLed;
    logic              hitSysTick;
    logic [DmemAw-1:0] dmemIdx;

    assign isDmem     = (ALUoutMEM[31:DmemAw+2] == '0);
    assign dmemIdx    = ALUoutMEM[DmemAw+1:2];
    assign hitTh      = (ALUoutMEM == AddrTh);
    assign hitTl      = (ALUoutMEM == AddrTl);
    assign hitTcon    = (ALUoutMEM == AddrTcon);
    assign hitLed     = (ALUoutMEM == AddrLed);
    assign hitSysTick = (ALUoutMEM == AddrSysTick);

    // Store strobes; SYSTICK has no write strobe, so stores to it fall away.
    logic wrDmem;
    logic wrTh;
    logic wrTl;
    logic wrTcon;
    logic wrLed;

    assign wrDmem = MemWriteMEM & isDmem & ~reset;
    assign wrTh   = MemWriteMEM & hitTh;
    assign wrTl   = MemWriteMEM & hitTl;
    assign wrTcon = MemWriteMEM & hitTcon;
    assign wrLed  = MemWriteMEM & hitLed;

    // Data memory: not reset; reads are asynchronous so a same-cycle store
    // is only visible from the next cycle on.
    logic [31:0] dmem [DMEM_WORDS];

    always_ff @(posedge clk) begin
        if (wrDmem) begin
            dmem[dmemIdx] <= memwritedataMEM;
        end
    end

    // Peripheral registers
    logic [31:0] thQ, thD;
    logic [31:0] tlQ, tlD;
    logic [2:0]  tconQ, tconD;
    logic [7:0]  ledQ, ledD;
    logic [31:0] sysTickQ, sysTickD;
    logic        overflow;

    assign overflow = tconQ[0] && (tlQ == 32'hFFFF_FFFF);

    always_comb begin
        thD      = thQ;
        tlD      = tlQ;
        tconD    = tconQ;
        ledD     = ledQ;
        sysTickD = sysTickQ + 32'd1;

        if (wrTh) begin
            thD = memwritedataMEM;
        end

        if (tconQ[0]) begin
            tlD = overflow ? thQ : tlQ + 32'd1;
        end
        if (wrTl) begin
            tlD = memwritedataMEM;
        end

        if (wrTcon) begin
            tconD = memwritedataMEM[2:0];
        end
        // A hardware overflow wins over a software clear in the same cycle.
        tconD[2] = tconD[2] | (overflow & tconQ[1]);

        if (wrLed) begin
            ledD = memwritedataMEM[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            thQ      <= '0;
            tlQ      <= '0;
            tconQ    <= '0;
            ledQ     <= '0;
            sysTickQ <= '0;
        end else begin
            thQ      <= thD;
            tlQ      <= tlD;
            tconQ    <= tconD;
            ledQ     <= ledD;
            sysTickQ <= sysTickD;
        end
    end

    assign leds      = ledQ;
    assign intterupt = tconQ[2];

    // Load path
    logic [31:0] memread;

    always_comb begin
        memread = '0;
        if (MemReadMEM) begin
            if (isDmem) begin
                memread = dmem[dmemIdx];
            end else if (hitTh) begin
                memread = thQ;
            end else if (hitTl) begin
                memread = tlQ;
            end else if (hitTcon) begin
                memread = {29'd0, tconQ};
            end else if (hitLed) begin
                memread = {24'd0, ledQ};
            end else if (hitSysTick) begin
                memread = sysTickQ;
            end
        end
    end

    assign wbdataMEM = MemtoRegMEM ? memread : ALUoutMEM;

endmodule
